note_display_ctrl: RTL and testbench
====================================

NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 6, frames a note stays lit after its last request; legal range 1..15.
REQ-002 Parameter CNT_W, default 4, width of each per-note hold counter.
REQ-003 vga_clk  input  1  single clock for the whole block; all registers update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 vsync  input  1  VGA vertical sync, active-low, synchronous to vga_clk.
REQ-006 mode  input  1  source select: 0 = free play, 1 = auto-play.
REQ-007 key_note  input  8  live keyboard level; bit0..bit6 = C,D,E,F,G,A,B; bit7 ignored.
REQ-008 play_note  input  8  auto-play note vector, same bit map; bit7 ignored.
REQ-009 play_valid  input  1  single-cycle strobe qualifying play_note.
REQ-010 note  output  8  registered note-highlight vector for the notes display; bit7 always 0.
REQ-011 lit_cnt  output  3  registered count of set bits in note[6:0].
REQ-012 frame_tick  output  1  registered copy of the internal frame tick, delayed one cycle.

Function
REQ-013 Registered copy vs_d of vsync; tick = vs_d & ~vsync, i.e. the first cycle vsync is seen low.
REQ-014 Request vector req[6:0] = key_note[6:0] when mode=0; = play_note[6:0] when mode=1 and play_valid=1; else 0.
REQ-015 Sticky pending[6:0] accumulates req between ticks: pending <= pending | req on non-tick cycles.
REQ-016 On a tick cycle, effective request eff = pending | req (a request coinciding with the tick is counted in that frame); pending <= 0.
REQ-017 Per note i on a tick cycle: eff[i]=1 -> cnt[i] <= HOLD_FRAMES; else cnt[i]!=0 -> cnt[i] <= cnt[i]-1; else hold 0.
REQ-018 Counters change only on tick cycles (apart from reset and mode change).
REQ-019 On a tick cycle, note[i] <= (next value of cnt[i] != 0); note changes only on tick cycles, never mid-frame.
REQ-020 lit_cnt <= popcount of the next note[6:0], updated in the same edge as note; range 0..7, no overflow.
REQ-021 Latency: request to note assertion = edge ending the next tick cycle; a single request lights the note for exactly HOLD_FRAMES frame updates.
REQ-022 Re-request of a lit note reloads its counter to HOLD_FRAMES (retrigger, no accumulation).
REQ-023 Registered mode_d; a mode change (mode != mode_d) clears pending and all cnt in that cycle; req in that cycle is discarded; note and lit_cnt clear at the next tick.
REQ-024 If a mode change and a tick coincide, the clear wins: cnt=0, pending=0, note<=0, lit_cnt<=0.
REQ-025 play_valid and play_note are ignored when mode=0; key_note is ignored when mode=1.
REQ-026 vsync held low produces one tick only; vsync held high produces no ticks and the outputs freeze.

Reset
REQ-027 While rst=1: note=0, lit_cnt=0, frame_tick=0, pending=0, all cnt=0, vs_d=1, mode_d=mode.
REQ-028 No tick is generated in the first cycle after reset release even if vsync is low.
REQ-029 Reset asserted mid-frame discards all pending requests and lit notes in that cycle.

Verification
REQ-030 mode=0, key_note=8'h01 for 3 cycles mid-frame, HOLD_FRAMES=6 -> note=8'h01 after the next tick for exactly 6 ticks, then 8'h00; lit_cnt 1 then 0.
REQ-031 mode=1, play_valid pulse with play_note=8'h60 in the tick cycle itself -> note=8'h60, lit_cnt=2 after that tick.
REQ-032 mode=0, key_note=8'h04 mid-frame, then again 3 frames later -> note bit2 stays 1 for 3+6=9 consecutive ticks.
REQ-033 mode=1, play_valid=0 with play_note=8'h7F; then mode=0 with play_valid=1 -> note stays 8'h00.
REQ-034 Notes lit (note=8'h1F, lit_cnt=5), mode toggles 0->1 in a tick cycle -> note=8'h00, lit_cnt=0 after that edge; pending empty.
REQ-035 vsync held low 100 cycles, key_note=8'hFF -> one tick only; note=8'h7F (bit7 0), lit_cnt=7; frame_tick high for exactly one cycle.

Source files
------------

// File: rtl/note_display_ctrl.sv
// Note-highlight controller: collects keyboard or auto-play note requests during a
// video frame and lights each requested note for HOLD_FRAMES frame updates.
module note_display_ctrl #(
    parameter int HOLD_FRAMES = 6,
    parameter int CNT_W       = 4
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       mode,
    input  logic [7:0] key_note,
    input  logic [7:0] play_note,
    input  logic       play_valid,
    output logic [7:0] note,
    output logic [2:0] lit_cnt,
    output logic       frame_tick
);

    localparam int              NOTES    = 7;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_FRAMES);

    // Number of set bits in a 7-bit note vector; the result never exceeds 7.
    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < NOTES; i++) begin
            s = s + {2'b00, v[i]};
        end
        return s;
    endfunction

    logic                vs_d_r;
    logic                mode_d_r;
    logic                armed_r;
    logic [6:0]          pending_r;
    logic [CNT_W-1:0]    cnt_r     [NOTES];
    logic [CNT_W-1:0]    cnt_nxt_s [NOTES];
    logic                tick_s;
    logic                mode_chg_s;
    logic [6:0]          req_s;
    logic [6:0]          eff_s;
    logic [6:0]          pending_nxt_s;
    logic [6:0]          note_nxt_s;
    logic                unused_bits_s;

    // armed_r suppresses a tick in the first cycle after reset, when vs_d_r is forced high.
    assign tick_s        = armed_r & vs_d_r & ~vsync;
    assign mode_chg_s    = (mode != mode_d_r);
    assign eff_s         = pending_r | req_s;
    assign unused_bits_s = key_note[7] ^ play_note[7];

    // Select the request source; a mode change discards whatever arrives in that cycle.
    always_comb begin
        req_s = 7'd0;
        if (mode_chg_s) begin
            req_s = 7'd0;
        end else if (mode == 1'b0) begin
            req_s = key_note[6:0];
        end else if (play_valid) begin
            req_s = play_note[6:0];
        end else begin
            req_s = 7'd0;
        end
    end

    // Pending requests accumulate within a frame and are consumed by the tick.
    always_comb begin
        pending_nxt_s = pending_r;
        if (mode_chg_s) begin
            pending_nxt_s = 7'd0;
        end else if (tick_s) begin
            pending_nxt_s = 7'd0;
        end else begin
            pending_nxt_s = pending_r | req_s;
        end
    end

    // Per-note hold counters: reload on request, otherwise count down once per frame.
    always_comb begin
        for (int i = 0; i < NOTES; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (mode_chg_s) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (tick_s) begin
                if (eff_s[i]) begin
                    cnt_nxt_s[i] = CNT_HOLD;
                end else if (cnt_r[i] != CNT_ZERO) begin
                    cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                end else begin
                    cnt_nxt_s[i] = CNT_ZERO;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            note_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
        end
    end

    // Edge detect, mode tracking and request/counter state.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            vs_d_r    <= 1'b1;
            mode_d_r  <= mode;
            armed_r   <= 1'b0;
            pending_r <= 7'd0;
            for (int i = 0; i < NOTES; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            vs_d_r    <= vsync;
            mode_d_r  <= mode;
            armed_r   <= 1'b1;
            pending_r <= pending_nxt_s;
            for (int i = 0; i < NOTES; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Display outputs only move on a tick, so the picture never changes mid-frame.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            note       <= 8'h00;
            lit_cnt    <= 3'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick_s;
            if (tick_s) begin
                note    <= {1'b0, note_nxt_s};
                lit_cnt <= popcount7(note_nxt_s);
            end else begin
                note    <= note;
                lit_cnt <= lit_cnt;
            end
        end
    end

endmodule

// File: tb/tb_note_display_ctrl.sv
// Scoreboard bench for note_display_ctrl: a frame-level reference model predicts
// the display state, a monitor compares it against the DUT every cycle.
module tb_note_display_ctrl;

    localparam int HOLD = 6;

    logic       vga_clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       mode;
    logic [7:0] key_note;
    logic [7:0] play_note;
    logic       play_valid;
    logic [7:0] note;
    logic [2:0] lit_cnt;
    logic       frame_tick;

    always #5 vga_clk = ~vga_clk;

    note_display_ctrl #(.HOLD_FRAMES(HOLD), .CNT_W(4)) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .vsync      (vsync),
        .mode       (mode),
        .key_note   (key_note),
        .play_note  (play_note),
        .play_valid (play_valid),
        .note       (note),
        .lit_cnt    (lit_cnt),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [7:0] n;
        logic [2:0] l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: frames remaining per note, set of pending notes, previous inputs.
    int         m_left[7];
    logic [6:0] m_pend;
    logic       m_vs_prev, m_mode_prev, m_armed;
    logic [7:0] nx_note, vis_note;
    logic [2:0] nx_lit, vis_lit;
    logic       nx_ft, vis_ft;
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Predict the state after the coming clock edge from the current inputs.
    task automatic model_step();
        logic       tick, chg;
        logic [6:0] req, eff;
        int         lit;
        if (rst) begin
            for (int i = 0; i < 7; i++) m_left[i] = 0;
            m_pend = 7'd0; m_vs_prev = 1'b1; m_mode_prev = mode; m_armed = 1'b0;
            nx_note = 8'h00; nx_lit = 3'd0; nx_ft = 1'b0;
        end else begin
            tick = m_armed && m_vs_prev && !vsync;
            chg  = (mode != m_mode_prev);
            req  = 7'd0;
            if (!chg) req = mode ? (play_valid ? play_note[6:0] : 7'd0) : key_note[6:0];
            eff = m_pend | req;
            if (chg) begin
                for (int i = 0; i < 7; i++) m_left[i] = 0;
                m_pend = 7'd0;
            end else if (tick) begin
                for (int i = 0; i < 7; i++) begin
                    if (eff[i]) m_left[i] = HOLD;
                    else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
                end
                m_pend = 7'd0;
            end else begin
                m_pend = eff;
            end
            if (tick) begin
                lit = 0;
                nx_note = 8'h00;
                for (int i = 0; i < 7; i++) begin
                    if (m_left[i] > 0) begin
                        nx_note[i] = 1'b1;
                        lit++;
                    end
                end
                nx_lit = 3'(lit);
                q.push_back('{nx_note, nx_lit});
            end
            nx_ft = tick; m_vs_prev = vsync; m_mode_prev = mode; m_armed = 1'b1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge vga_clk);
        vis_note = nx_note; vis_lit = nx_lit; vis_ft = nx_ft;
        #1;
    endtask

    // One frame: vsync low for its first two cycles, inputs applied in [at, at+dur).
    task automatic frame(input int len, input int at, input int dur,
                         input logic [7:0] k, input logic [7:0] p, input logic pv);
        for (int c = 0; c < len; c++) begin
            vsync = (c < 2) ? 1'b0 : 1'b1;
            if (c >= at && c < at + dur) begin
                key_note = k; play_note = p; play_valid = pv;
            end else begin
                key_note = 8'h00; play_note = 8'h00; play_valid = 1'b0;
            end
            step();
        end
    endtask

    // Monitor: frame_tick marks a new display value, which is popped and compared.
    always @(negedge vga_clk) begin
        exp_t e;
        if (mon_en) begin
            check("frame_tick", {31'd0, frame_tick}, {31'd0, vis_ft});
            if (frame_tick) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_update at %0t: note %0h with no expected entry", $time, note);
                end else begin
                    e = q.pop_front();
                    check("note_update", {24'd0, note}, {24'd0, e.n});
                    check("lit_cnt_update", {29'd0, lit_cnt}, {29'd0, e.l});
                end
            end else begin
                check("note_hold", {24'd0, note}, {24'd0, vis_note});
                check("lit_cnt_hold", {29'd0, lit_cnt}, {29'd0, vis_lit});
            end
        end
    end

    initial begin
        int len, low;
        rst = 1'b1; vsync = 1'b1; mode = 1'b0;
        key_note = 8'h00; play_note = 8'h00; play_valid = 1'b0;
        step(); step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        // Single key for 3 cycles mid-frame
        frame(16, 6, 3, 8'h01, 8'h00, 1'b0);
        repeat (8) frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Retrigger three frames later
        frame(16, 5, 1, 8'h04, 8'h00, 1'b0);
        frame(16, 0, 0, 8'h00, 8'h00, 1'b0);
        frame(16, 0, 0, 8'h00, 8'h00, 1'b0);
        frame(16, 5, 1, 8'h04, 8'h00, 1'b0);
        repeat (8) frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Auto-play strobe in the tick cycle itself
        mode = 1'b1; vsync = 1'b1;
        repeat (3) step();
        frame(16, 0, 1, 8'h00, 8'h60, 1'b1);
        repeat (7) frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Unqualified play_note, then play_valid in free-play mode
        frame(16, 4, 2, 8'h00, 8'h7F, 1'b0);
        mode = 1'b0; vsync = 1'b1;
        repeat (3) step();
        frame(16, 4, 2, 8'h00, 8'h7F, 1'b1);
        frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Mode toggle in a tick cycle with notes lit and a request pending
        frame(16, 4, 2, 8'h1F, 8'h00, 1'b0);
        frame(16, 10, 1, 8'h60, 8'h00, 1'b0);
        key_note = 8'h00; vsync = 1'b0; mode = 1'b1;
        step(); step();
        vsync = 1'b1;
        repeat (14) step();
        frame(16, 0, 0, 8'h00, 8'h00, 1'b0);
        frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Reset mid-frame with lit notes and a pending request
        mode = 1'b0; vsync = 1'b1;
        repeat (3) step();
        frame(16, 4, 2, 8'h03, 8'h00, 1'b0);
        vsync = 1'b0; step(); step(); vsync = 1'b1;
        key_note = 8'h08; repeat (3) step(); key_note = 8'h00;
        rst = 1'b1; step(); step(); rst = 1'b0;
        repeat (6) step();
        repeat (3) frame(16, 0, 0, 8'h00, 8'h00, 1'b0);

        // Reset released while vsync is already low
        vsync = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        repeat (5) step();
        vsync = 1'b1; repeat (4) step();
        frame(16, 4, 1, 8'h10, 8'h00, 1'b0);

        // vsync held low 100 cycles with every key pressed, then held high
        key_note = 8'hFF; vsync = 1'b0;
        repeat (100) step();
        key_note = 8'h00; vsync = 1'b1;
        repeat (60) step();

        // Randomized frames with occasional mode flips and resets
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(24, 6);
            low = $urandom_range(4, 1);
            if ($urandom_range(19, 0) == 0) low = len;
            for (int c = 0; c < len; c++) begin
                vsync      = (c < low) ? 1'b0 : 1'b1;
                key_note   = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
                play_note  = 8'($urandom);
                play_valid = ($urandom_range(3, 0) == 0);
                if ($urandom_range(79, 0) == 0) mode = ~mode;
                rst = ($urandom_range(299, 0) == 0);
                step();
            end
        end
        rst = 1'b0; key_note = 8'h00; play_valid = 1'b0; vsync = 1'b1;
        repeat (3) step();
        mon_en = 1'b0;
        @(negedge vga_clk);

        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL missing_updates: %0d expected updates never seen, required 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
